sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost-full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold (0..DEPTH-1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 wr_en  input  1  write request.
REQ-008 rd_en  input  1  read request.
REQ-009 din  input  WIDTH  write data.
REQ-010 dout  output  WIDTH  registered read data.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 almost_full  output  1  count >= AF_LEVEL.
REQ-014 almost_empty  output  1  count <= AE_LEVEL.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 overflow  output  1  sticky rejected-write flag.
REQ-017 underflow  output  1  sticky rejected-read flag.

Function
REQ-018 Read accepted (rd_ok) iff rd_en && !empty; write accepted (wr_ok) iff wr_en && (!full || rd_ok).
REQ-019 wr_ok: din stored at wptr; wptr advances modulo DEPTH at the same edge.
REQ-020 rd_ok: dout loaded with entry at rptr at that edge (1-cycle latency); rptr advances modulo DEPTH.
REQ-021 dout holds its value on cycles without rd_ok.
REQ-022 count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
REQ-023 Full with wr_en && rd_en: both accepted, count stays DEPTH, full stays 1.
REQ-024 Empty with wr_en && rd_en: write accepted, read rejected (no bypass), count becomes 1.
REQ-025 full, empty, almost_full, almost_empty are combinational decodes of registered count only; no input-to-output combinational path.
REQ-026 Rejected write leaves memory, wptr and count unchanged; rejected read leaves dout, rptr and count unchanged.
REQ-027 Pointer wrap is seamless: DEPTH+k in-order writes/reads return data in write order.

Reset
REQ-028 rst_n low forces, asynchronously: wptr=0, rptr=0, count=0, dout=0, overflow=0, underflow=0.
REQ-029 After reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-030 Storage array is not reset; contents are unobservable until rewritten.
REQ-031 Reset asserted mid-operation discards all stored entries; no accept occurs on the edge where rst_n is low.
REQ-032 Reset deassertion is synchronised by the integrator; block requires no extra flush cycle.

Configuration
REQ-033 Macro SYNC_FIFO_ERR_FLAGS_EN compiles in overflow/underflow detection.
REQ-034 Defined: overflow sets on any edge with wr_en && !wr_ok; underflow sets on any edge with rd_en && empty; both clear only on reset.
REQ-035 Undefined: overflow and underflow ports remain present and are tied to constant 0; no flag logic.

Structure
REQ-036 Package sync_fifo_pkg holds default constants (WIDTH/DEPTH defaults) and a count-width function; no per-instance state.
REQ-037 Sub-module sync_fifo_mem: DEPTH x WIDTH array, one write port, one registered read port; control/pointers stay in sync_fifo.

Verification
REQ-038 Reset then 16 writes of 0x00..0x0F -> full=1 after 16th, count=16, almost_full=1 from count 14.
REQ-039 Full, 16 reads -> dout sequence 0x00..0x0F, each valid the cycle after rd_en, empty=1 after last.
REQ-040 Full, wr_en=rd_en=1 with din=0xAA -> count stays 16, dout=oldest entry, 0xAA read out 16 reads later.
REQ-041 Empty, rd_en=1 -> dout unchanged, count 0, underflow=1 (macro on) / 0 (macro off); full + wr_en alone -> overflow=1 likewise.
REQ-042 Write 10 entries, read 10, repeat 3x (wrap) -> data order preserved, count 0 at end.
REQ-043 Write 5 entries, pulse rst_n low mid-cycle -> empty=1, count=0, dout=0 immediately, before next clk edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helper for sync_fifo.
package sync_fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Occupancy needs one extra bit so that a value of DEPTH can be represented.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy flags and registered read data.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [AW-1:0] wptr, rptr;
    logic          rd_ok, wr_ok;

    // Flags decode the registered count only, so no input reaches them combinationally.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside it.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (dout)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_ok) overflow  <= 1'b1;
            if (rd_en && empty)  underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default WIDTH=8, DEPTH=16).
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en;
    logic [7:0] din, dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int checks = 0;
    int failures = 0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic EF = 1'b1;
`else
    localparam logic EF = 1'b0;
`endif

    sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        #23;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; din = 8'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
            chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 2));
            chk("fill_full", 32'(full), 32'(i == 15));
        end
        wr_en = 1'b0;

        // Drain: data arrives the cycle after rd_en
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_dout", 32'(dout), 32'(i));
            chk("drain_count", 32'(count), 32'(15 - i));
        end
        rd_en = 1'b0;
        chk("drain_empty", 32'(empty), 1);

        // Refill with 0x10..0x1F, then simultaneous read/write at full
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; din = 8'(8'h10 + i);
            tick();
        end
        rd_en = 1'b1; din = 8'hAA;
        tick();
        chk("fullrw_count", 32'(count), 16);
        chk("fullrw_full", 32'(full), 1);
        chk("fullrw_dout", 32'(dout), 32'h10);
        rd_en = 1'b0;
        din = 8'h77;
        tick();
        chk("ovf_count", 32'(count), 16);
        chk("ovf_flag", 32'(overflow), 32'(EF));
        chk("ovf_dout", 32'(dout), 32'h10);
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("rw_drain", 32'(dout), (i < 15) ? 32'(8'h11 + i) : 32'hAA);
        end
        chk("rw_empty", 32'(empty), 1);

        // Read while empty is rejected
        tick();
        chk("unf_dout", 32'(dout), 32'hAA);
        chk("unf_count", 32'(count), 0);
        chk("unf_flag", 32'(underflow), 32'(EF));

        // Empty with both requests: write only, no bypass
        wr_en = 1'b1; din = 8'h55;
        tick();
        chk("erw_count", 32'(count), 1);
        chk("erw_dout", 32'(dout), 32'hAA);
        wr_en = 1'b0;
        tick();
        chk("erw_read", 32'(dout), 32'h55);
        chk("erw_empty", 32'(empty), 1);
        rd_en = 1'b0;

        // Pointer wrap: 3x (write 10, read 10)
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                wr_en = 1'b1; din = 8'(8'h30 + r * 16 + i);
                tick();
            end
            wr_en = 1'b0;
            for (int i = 0; i < 10; i++) begin
                rd_en = 1'b1;
                tick();
                chk("wrap_dout", 32'(dout), 32'(8'h30 + r * 16 + i));
            end
            rd_en = 1'b0;
        end
        chk("wrap_count", 32'(count), 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; din = 8'(8'hC0 + i);
            tick();
        end
        chk("pre_rst_count", 32'(count), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_count", 32'(count), 0);
        chk("arst_dout", 32'(dout), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_unf", 32'(underflow), 0);
        tick();
        chk("rst_hold_count", 32'(count), 0);
        wr_en = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
